// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, FSM state types and bit-reverse helper for the FFT input path
package fft_pkg;
  localparam int FLOAT18_W = 18;
  localparam int CPLX_W    = 2 * FLOAT18_W;
  localparam int MAX_LOG2N = 14;

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;
  typedef enum logic       {R_IDLE, R_STREAM}       rd_state_t;

  // Reverses the low 'width' bits of value; upper bits of the result are zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value, input int width);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2N; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction
endpackage

// File: rtl/fft_sdp_ram.sv
// rtl/fft_sdp_ram.sv - simple dual-port RAM, write-only port A, read-only port B with registered read
module fft_sdp_ram
  import fft_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = CPLX_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/float18_frame_buffer.sv
// rtl/float18_frame_buffer.sv - ping-pong frame buffer between float18 converter and FFT core
module float18_frame_buffer
  import fft_pkg::*;
#(
  parameter int LOG2N  = 10,
  parameter int DW     = CPLX_W,
  parameter bit BITREV = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic [LOG2N-1:0] out_index,
  output logic             overflow
);
  localparam logic [LOG2N-1:0] LAST = LOG2N'((2**LOG2N) - 1);

  wr_state_t        r_wstate, w_wstate_nxt;
  rd_state_t        r_rstate, w_rstate_nxt;
  logic [LOG2N-1:0] r_wcnt, r_rcnt, w_widx, w_ridx, r_pend_idx;
  logic             r_wbank, w_wbank, w_we, w_take, w_drop_start, w_fill_done;
  logic             r_rbank, w_rbank, w_re, r_pend, r_pend_bank, r_overflow;
  logic [1:0]       r_full, r_rdy, w_free, w_release, w_filled, w_claim, r_qcnt;
  logic [DW-1:0]    r_qdata [2];
  logic [LOG2N-1:0] r_qidx [2];
  logic             r_qbank [2];
  logic [DW-1:0]    w_rdata;
  logic [2:0]       w_occ;
  logic             w_pop, w_space, w_slot;

  // A bank whose last sample leaves this cycle may be claimed by a frame starting this cycle.
  assign w_pop     = out_valid && out_ready;
  assign w_release = (w_pop && r_qidx[0] == LAST) ? (r_qbank[0] ? 2'b10 : 2'b01) : 2'b00;
  assign w_free    = ~r_full | w_release;
  assign w_filled  = w_fill_done ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
  assign w_widx    = BITREV ? LOG2N'(bitrev(MAX_LOG2N'(r_wcnt), LOG2N)) : r_wcnt;

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_we         = 1'b0;
    w_wbank      = r_wbank;
    w_take       = 1'b0;
    w_drop_start = 1'b0;
    w_fill_done  = 1'b0;
    case (r_wstate)
      W_IDLE: if (in_valid) begin
        if (w_free[0] || w_free[1]) begin
          w_take       = 1'b1;
          w_we         = 1'b1;
          w_wbank      = !w_free[0];
          w_wstate_nxt = W_FILL;
        end else begin
          w_drop_start = 1'b1;
          w_wstate_nxt = W_DROP;
        end
      end
      W_FILL: if (in_valid) begin
        w_we = 1'b1;
        if (r_wcnt == LAST) begin
          w_fill_done  = 1'b1;
          w_wstate_nxt = W_IDLE;
        end
      end
      W_DROP:  if (in_valid && r_wcnt == LAST) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Issue a read only when its data is sure to find a skid slot one cycle later.
  assign w_occ   = 3'(r_qcnt) + 3'(r_pend) - 3'(w_pop);
  assign w_space = w_occ <= 3'd1;

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_re         = 1'b0;
    w_rbank      = r_rbank;
    w_ridx       = r_rcnt;
    w_claim      = 2'b00;
    case (r_rstate)
      R_IDLE: if ((|r_rdy) && w_space) begin
        w_re         = 1'b1;
        w_rbank      = r_rdy[1];
        w_ridx       = '0;
        w_claim      = r_rdy[1] ? 2'b10 : 2'b01;
        w_rstate_nxt = R_STREAM;
      end
      R_STREAM: if (w_space) begin
        w_re = 1'b1;
        if (r_rcnt == LAST) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate   <= W_IDLE;
      r_rstate   <= R_IDLE;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_wbank    <= 1'b0;
      r_rbank    <= 1'b0;
      r_overflow <= 1'b0;
      r_full     <= 2'b00;
      r_rdy      <= 2'b00;
      r_pend     <= 1'b0;
      r_pend_idx <= '0;
      r_pend_bank <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      if (in_valid)     r_wcnt     <= r_wcnt + 1'b1;
      if (w_take)       r_wbank    <= w_wbank;
      if (w_drop_start) r_overflow <= 1'b1;
      r_full <= (r_full & ~w_release) | w_filled;
      r_rdy  <= (r_rdy & ~w_claim) | w_filled;
      r_pend <= w_re;
      if (w_re) begin
        r_rbank     <= w_rbank;
        r_rcnt      <= w_ridx + 1'b1;
        r_pend_idx  <= w_ridx;
        r_pend_bank <= w_rbank;
      end
    end
  end

  fft_sdp_ram #(.AW(LOG2N + 1), .DW(DW)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({w_wbank, w_widx}),
    .i_wdata (in_data),
    .i_re    (w_re),
    .i_raddr ({w_rbank, w_ridx}),
    .o_rdata (w_rdata)
  );

  // Two-entry skid queue; slot 0 is the head presented on the outputs.
  assign w_slot = (r_qcnt == 2'd2) || (r_qcnt == 2'd1 && !w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_qcnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_qdata[i] <= '0;
        r_qidx[i]  <= '0;
        r_qbank[i] <= 1'b0;
      end
    end else begin
      if (w_pop) begin
        r_qdata[0] <= r_qdata[1];
        r_qidx[0]  <= r_qidx[1];
        r_qbank[0] <= r_qbank[1];
      end
      if (r_pend) begin
        r_qdata[w_slot] <= w_rdata;
        r_qidx[w_slot]  <= r_pend_idx;
        r_qbank[w_slot] <= r_pend_bank;
      end
      r_qcnt <= r_qcnt + 2'(r_pend) - 2'(w_pop);
    end
  end

  assign out_valid = r_qcnt != 2'd0;
  assign out_data  = r_qdata[0];
  assign out_index = r_qidx[0];
  assign out_sof   = out_valid && r_qidx[0] == '0;
  assign out_eof   = out_valid && r_qidx[0] == LAST;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_float18_frame_buffer.sv
// tb/tb_float18_frame_buffer.sv - bench for float18_frame_buffer, both read orders side by side
module tb_float18_frame_buffer;
  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int DW    = 36;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, out_ready;
  logic [DW-1:0]    in_data;
  logic             ov0, ov1, sof0, sof1, eof0, eof1, ovf0, ovf1;
  logic [DW-1:0]    od0, od1;
  logic [LOG2N-1:0] oi0, oi1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_valid = -1;

  int            m_cnt;
  bit            m_acc [2];
  int            m_inuse [2];
  bit            m_ovf [2];
  logic [DW-1:0] m_frame [N];
  exp_t          eq0[$], eq1[$];
  logic [DW-1:0] rec0[$], rec1[$];
  int            tcyc0[$];
  bit            hold [2];
  logic [DW-1:0] p_data [2];
  int            p_idx [2];
  int            t1_exp [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  float18_frame_buffer #(.LOG2N(LOG2N), .DW(DW), .BITREV(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sof(sof0),
    .out_eof(eof0), .out_index(oi0), .overflow(ovf0)
  );

  float18_frame_buffer #(.LOG2N(LOG2N), .DW(DW), .BITREV(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sof(sof1),
    .out_eof(eof1), .out_index(oi1), .overflow(ovf1)
  );

  function automatic int rev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_dut(input int d);
    logic v, s, e, f;
    logic [DW-1:0] dat;
    int idx, qsz;
    exp_t x;
    v   = d ? ov1 : ov0;
    s   = d ? sof1 : sof0;
    e   = d ? eof1 : eof0;
    f   = d ? ovf1 : ovf0;
    dat = d ? od1 : od0;
    idx = d ? int'(oi1) : int'(oi0);
    qsz = d ? eq1.size() : eq0.size();
    chk($sformatf("overflow_d%0d", d), 64'(f), 64'(m_ovf[d]));
    if (hold[d]) begin
      chk($sformatf("hold_valid_d%0d", d), 64'(v), 64'(1));
      chk($sformatf("hold_data_d%0d", d), 64'(dat), 64'(p_data[d]));
      chk($sformatf("hold_index_d%0d", d), 64'(idx), 64'(p_idx[d]));
    end
    if (v) begin
      if (d == 1 && first_valid < 0) first_valid = cyc;
      if (qsz == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid_d%0d got=valid exp=no_pending_sample", d);
      end else begin
        if (d == 1) x = eq1[0];
        else        x = eq0[0];
        chk($sformatf("data_d%0d", d), 64'(dat), 64'(x.data));
        chk($sformatf("index_d%0d", d), 64'(idx), 64'(x.idx));
        chk($sformatf("sof_d%0d", d), 64'(s), 64'(x.idx == 0));
        chk($sformatf("eof_d%0d", d), 64'(e), 64'(x.idx == N - 1));
        if (out_ready) begin
          if (d == 1) begin
            x = eq1.pop_front();
            rec1.push_back(dat);
          end else begin
            x = eq0.pop_front();
            rec0.push_back(dat);
            tcyc0.push_back(cyc);
          end
          if (x.idx == N - 1) m_inuse[d]--;
        end
      end
    end
    hold[d]   = v && !out_ready;
    p_data[d] = dat;
    p_idx[d]  = idx;
  endtask

  task automatic model_strobe(input logic [DW-1:0] id);
    exp_t x;
    if (m_cnt == 0) begin
      for (int d = 0; d < 2; d++) begin
        m_acc[d] = (m_inuse[d] < 2);
        if (m_acc[d]) m_inuse[d]++;
        else          m_ovf[d] = 1'b1;
      end
    end
    m_frame[m_cnt] = id;
    if (m_cnt == N - 1) begin
      for (int i = 0; i < N; i++) begin
        x.idx = i;
        if (m_acc[0]) begin x.data = m_frame[i];       eq0.push_back(x); end
        if (m_acc[1]) begin x.data = m_frame[rev3(i)]; eq1.push_back(x); end
      end
    end
    m_cnt = (m_cnt + 1) % N;
  endtask

  task automatic step(input bit iv, input logic [DW-1:0] id, input bit rdy);
    in_valid  = iv;
    in_data   = id;
    out_ready = rdy;
    check_dut(0);
    check_dut(1);
    if (iv) model_strobe(id);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0;
    for (int d = 0; d < 2; d++) begin
      m_acc[d] = 1'b0; m_inuse[d] = 0; m_ovf[d] = 1'b0; hold[d] = 1'b0;
    end
    eq0.delete(); eq1.delete(); rec0.delete(); rec1.delete(); tcyc0.delete();
    first_valid = -1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((eq0.size() != 0 || eq1.size() != 0) && n < 200) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    chk("drain_complete", 64'(eq0.size() + eq1.size()), 64'(0));
    repeat (4) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int s7, n, sent;
    logic [63:0] rnd;

    // 1: single bit-reversed frame, latency and order
    do_reset();
    chk("reset_valid", 64'({ov0, ov1}), 64'(0));
    chk("reset_index", 64'({oi0, oi1}), 64'(0));
    chk("reset_data", 64'(od1), 64'(0));
    s7 = 0;
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) s7 = cyc;
      step(1'b1, DW'(k), 1'b1);
    end
    drain();
    chk("t1_latency", 64'(first_valid - s7), 64'(3));
    chk("t1_count", 64'(rec1.size()), 64'(8));
    for (int i = 0; i < 8 && i < rec1.size(); i++) chk("t1_order", 64'(rec1[i]), 64'(t1_exp[i]));

    // 2: natural order, two back-to-back frames then a third starting on the release cycle
    do_reset();
    for (int k = 0; k < 2 * N; k++) step(1'b1, DW'(k), 1'b1);
    step(1'b0, '0, 1'b1);
    for (int k = 2 * N; k < 3 * N; k++) step(1'b1, DW'(k), 1'b1);
    drain();
    chk("t2_count", 64'(rec0.size()), 64'(24));
    for (int i = 0; i < rec0.size(); i++) chk("t2_order", 64'(rec0[i]), 64'(i));
    if (tcyc0.size() >= 16) chk("t2_no_bubble", 64'(tcyc0[15] - tcyc0[0]), 64'(15));
    chk("t2_overflow", 64'({ovf0, ovf1}), 64'(0));

    // 3: random strobes and random backpressure
    do_reset();
    sent = 0;
    while (sent < 4 * N) begin
      rnd = {$urandom, $urandom};
      if ($urandom_range(0, 9) < 4) begin
        step(1'b1, rnd[DW-1:0], 1'($urandom_range(0, 1)));
        sent++;
      end else begin
        step(1'b0, '0, 1'($urandom_range(0, 1)));
      end
    end
    drain();
    chk("t3_same_count", 64'(rec1.size()), 64'(rec0.size()));

    // 4: stalled output, third frame dropped
    do_reset();
    for (int k = 0; k < 3 * N; k++) step(1'b1, DW'(200 + k), 1'b0);
    step(1'b0, '0, 1'b0);
    chk("t4_overflow_d0", 64'(ovf0), 64'(1));
    chk("t4_overflow_d1", 64'(ovf1), 64'(1));
    drain();
    chk("t4_buffered_count", 64'(rec1.size()), 64'(16));
    for (int k = 0; k < N; k++) step(1'b1, DW'(300 + k), 1'b1);
    drain();
    chk("t4_total_count", 64'(rec1.size()), 64'(24));
    if (rec0.size() == 24) chk("t4_frame3_last", 64'(rec0[23]), 64'(307));

    // 5: new frame starts in the cycle the oldest bank is released
    do_reset();
    for (int k = 0; k < 2 * N; k++) step(1'b1, DW'(400 + k), 1'b0);
    n = 0;
    while (!(ov1 && eof1) && n < 40) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    chk("t5_eof_seen", 64'(ov1 && eof1), 64'(1));
    for (int k = 0; k < N; k++) step(1'b1, DW'(500 + k), 1'b1);
    drain();
    chk("t5_overflow", 64'({ovf0, ovf1}), 64'(0));
    chk("t5_count", 64'(rec0.size()), 64'(24));

    // 6: reset in the middle of a frame
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, DW'(50 + k), 1'b1);
    do_reset();
    chk("t6_valid", 64'({ov0, ov1}), 64'(0));
    chk("t6_data", 64'(od0 | od1), 64'(0));
    chk("t6_index", 64'({oi0, oi1}), 64'(0));
    chk("t6_marks", 64'({sof0, sof1, eof0, eof1, ovf0, ovf1}), 64'(0));
    for (int k = 0; k < N; k++) step(1'b1, DW'(100 + k), 1'b1);
    drain();
    chk("t6_count", 64'(rec1.size()), 64'(8));
    for (int i = 0; i < 8 && i < rec1.size(); i++) chk("t6_order", 64'(rec1[i]), 64'(100 + t1_exp[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
